// File: rtl/mult_dot_accumulator_if.sv
// Handshake and multiplier-side bundle for mult_dot_accumulator.
// The slave modport is the accumulator; the master is its environment.
interface mult_dot_accumulator_if #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 10
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic [WIDTH-1:0]   mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0] mul_y;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   out_data;

   modport slave (
      input  in_valid, in_a, in_b, mul_y, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_data
   );

   modport master (
      output in_valid, in_a, in_b, mul_y, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_data
   );
endinterface

// File: rtl/mult_dot_accumulator.sv
// Issue/collect wrapper around a LAT-cycle pipelined multiplier: sums LEN products per result
// into a 2-entry FIFO. Define MULT_DOT_ACC_SAT_EN to saturate the sum instead of wrapping.
module mult_dot_accumulator #(
   parameter int WIDTH = 4,
   parameter int LEN   = 4,
   parameter int LAT   = 3,
   parameter int ACC_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mult_dot_accumulator_if.slave bus
);
   localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int PEND_W = $clog2(LAT + 3);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   logic [CNT_W-1:0]  icnt_r;
   logic [LAT-1:0]    tag_v_r;
   logic [LAT-1:0]    tag_l_r;
   logic [ACC_W-1:0]  acc_r;
   logic [ACC_W-1:0]  head_r;
   logic [ACC_W-1:0]  tail_r;
   logic [1:0]        occ_r;
   logic              accept_s;
   logic              last_issue_s;
   logic              tap_v_s;
   logic              tap_l_s;
   logic              push_s;
   logic              pop_s;
   logic [PEND_W-1:0] pending_s;
   logic [ACC_W-1:0]  sum_s;

   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [2*WIDTH-1:0] y);
`ifdef MULT_DOT_ACC_SAT_EN
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(y);
      acc_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
      acc_add = a + ACC_W'(y);
`endif
   endfunction

   // Credits: FIFO entries plus vectors whose last product is still in flight
   always_comb begin
      pending_s = PEND_W'(occ_r);
      for (int i = 0; i < LAT; i++) begin
         pending_s = pending_s + PEND_W'(tag_l_r[i]);
      end
   end

   assign bus.in_ready  = !((icnt_r == CNT_LAST) && (pending_s == PEND_W'(2'd2)));
   assign accept_s      = bus.in_valid & bus.in_ready;
   assign last_issue_s  = accept_s & (icnt_r == CNT_LAST);
   assign bus.mul_a     = accept_s ? bus.in_a : '0;
   assign bus.mul_b     = accept_s ? bus.in_b : '0;
   assign tap_v_s       = tag_v_r[LAT-1];
   assign tap_l_s       = tag_l_r[LAT-1];
   assign sum_s         = acc_add(acc_r, bus.mul_y);
   assign push_s        = tap_v_s & tap_l_s;
   assign pop_s         = (occ_r != 2'd0) & bus.out_ready;
   assign bus.out_valid = (occ_r != 2'd0);
   assign bus.out_data  = head_r;

   // Issue counter, product tag pipe and running sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icnt_r  <= '0;
         tag_v_r <= '0;
         tag_l_r <= '0;
         acc_r   <= '0;
      end else begin
         if (accept_s) begin
            icnt_r <= (icnt_r == CNT_LAST) ? '0 : icnt_r + CNT_W'(1'b1);
         end
         tag_v_r[0] <= accept_s;
         tag_l_r[0] <= last_issue_s;
         for (int i = 1; i < LAT; i++) begin
            tag_v_r[i] <= tag_v_r[i-1];
            tag_l_r[i] <= tag_l_r[i-1];
         end
         if (tap_v_s) begin
            acc_r <= tap_l_s ? '0 : sum_s;
         end
      end
   end

   // Two-entry result FIFO; head_r is always the oldest entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r  <= 2'd0;
         head_r <= '0;
         tail_r <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  head_r <= sum_s;
               end else begin
                  tail_r <= sum_s;
               end
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               head_r <= tail_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  head_r <= sum_s;
               end else begin
                  head_r <= tail_r;
                  tail_r <= sum_s;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

   mult_dot_accumulator_chk u_chk (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push_s),
      .full (occ_r == 2'd2)
   );
endmodule

// Credit logic must never let a result arrive at a full FIFO.
module mult_dot_accumulator_chk (
   input logic clk,
   input logic rst_n,
   input logic push,
   input logic full
);
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule
